// File: rtl/reaction_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : reaction_ctl
//  Purpose  : Control FSM for the reaction timer (1 kHz clock, 1 cycle = 1 ms).
//             Generates the pseudo-random start delay, drives the downstream
//             BCD millisecond counter (clear / enable), consumes its overflow
//             pulse and flags early (cheat) and late responses.
//  Revision : 1.0  initial release
// ============================================================================
module reaction_ctl #(
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 12,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic react,
    input  logic time_late,
    output logic time_clr,
    output logic time_en,
    output logic led_go,
    output logic led_cheat,
    output logic led_late,
    output logic disp_en,
    output logic busy
);

    // Delay counter must hold the largest possible start delay.
    localparam int c_CNT_W = $clog2(MIN_DELAY_MS + 2**RAND_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_TIME  = 3'd2,
        ST_DONE  = 3'd3,
        ST_CHEAT = 3'd4,
        ST_LATE  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [15:0]        r_lfsr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_start_q;
    logic               r_react_q;

    logic               w_start_rise;
    logic               w_react_rise;
    logic               w_lfsr_fb;
    logic               w_load_delay;
    logic               w_cnt_dec;
    logic [c_CNT_W-1:0] w_delay;

    // A held button yields a single event on its rising edge only.
    assign w_start_rise = start & ~r_start_q;
    assign w_react_rise = react & ~r_react_q;

    // Fibonacci feedback for taps 16,14,13,11 in right-shift form.
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Start delay: fixed part plus a pseudo-random number of extra ms.
    assign w_delay = c_CNT_W'(MIN_DELAY_MS) + c_CNT_W'(r_lfsr[RAND_BITS-1:0]);

    // Button history registers for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_react_q <= 1'b0;
        end else begin
            r_start_q <= start;
            r_react_q <= react;
        end
    end

    // Free-running LFSR; its value at trial start picks the random delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    // Delay counter: loaded on entry to WAIT, counts down to zero while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_load_delay) begin
            r_cnt <= w_delay;
        end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and Moore output decode of the current state.
    always_comb begin
        w_next_state = r_state;
        w_load_delay = 1'b0;
        w_cnt_dec    = 1'b0;
        time_clr     = 1'b0;
        time_en      = 1'b0;
        led_go       = 1'b0;
        led_cheat    = 1'b0;
        led_late     = 1'b0;
        disp_en      = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                time_clr = 1'b1;
                if (w_start_rise) begin
                    w_next_state = ST_WAIT;
                    w_load_delay = 1'b1;
                end
            end
            ST_WAIT: begin
                time_clr = 1'b1;
                busy     = 1'b1;
                // An early press beats the delay expiring in the same cycle.
                if (w_react_rise) begin
                    w_next_state = ST_CHEAT;
                end else if (r_cnt == '0) begin
                    w_next_state = ST_TIME;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_TIME: begin
                time_en = 1'b1;
                led_go  = 1'b1;
                busy    = 1'b1;
                // Overflow wins: the counter wraps on this edge, so its value is useless.
                if (time_late) begin
                    w_next_state = ST_LATE;
                end else if (w_react_rise) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                disp_en = 1'b1;
                if (w_start_rise) begin
                    w_next_state = ST_WAIT;
                    w_load_delay = 1'b1;
                end
            end
            ST_CHEAT: begin
                led_cheat = 1'b1;
                if (w_start_rise) begin
                    w_next_state = ST_WAIT;
                    w_load_delay = 1'b1;
                end
            end
            ST_LATE: begin
                led_late = 1'b1;
                if (w_start_rise) begin
                    w_next_state = ST_WAIT;
                    w_load_delay = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
